// File: rtl/uart_rx_ctrl_pkg.sv
// Shared UART receive definitions: frame geometry, baud constant, sequencer state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_rx_ctrl_pkg;

  // 50 MHz system clock at 115200 baud
  localparam int BPS_CNT_115200 = 434;
  localparam int DATA_BITS      = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Receiver-side bundle between the line/baud generator and the UART receive sequencer.
// Latency: n/a (wires only).
// Backpressure: none; rx_done is a single-cycle strobe with data held until the next one.
interface uart_rx_ctrl_if
  import uart_rx_ctrl_pkg::*;
#(
  parameter int DW = DATA_BITS
);

  logic          rx_pin;
  logic          rx_en;
  logic          clk_bps;
  logic          count_sig;
  logic [DW-1:0] rx_data;
  logic          rx_done;
  logic          frame_err;
  logic          stall_err;
  logic          busy;

  // Receiver sees the line and baud tick, drives the run request and results
  modport slave (
    input  rx_pin, rx_en, clk_bps,
    output count_sig, rx_data, rx_done, frame_err, stall_err, busy
  );

  // Environment side: drives the line and tick, observes the receiver
  modport master (
    output rx_pin, rx_en, clk_bps,
    input  count_sig, rx_data, rx_done, frame_err, stall_err, busy
  );

endinterface

// File: rtl/uart_rx_ctrl_rx_sync_edge.sv
// Two-flop synchroniser for the async rx line plus a history flop for falling-edge detection.
// Latency: pin change visible on sync_o after 2 clocks; fall_o valid alongside it.
// Backpressure: none; flops reset to 1 so an idle-high line never looks like an edge.
module uart_rx_ctrl_rx_sync_edge (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic pin_i,
  output logic sync_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Synchronise the pin and keep one cycle of history for edge detection
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= pin_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART 8N1 receive sequencer: start detect, mid-bit sampling on clk_bps, byte + status out.
// Latency: START 3 clocks after pin falls; rx_done one clock after the stop-bit tick.
// Backpressure: none; rx_data held until next rx_done, rx_en=0 aborts the frame in one clock.
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int BPS_CNT   = BPS_CNT_115200,
  parameter int DATA_BITS = uart_rx_ctrl_pkg::DATA_BITS,
  parameter int WDOG_MULT = 2
) (
  input  logic           sysclk,
  input  logic           rst_n,
  uart_rx_ctrl_if.slave  rx_if
);

  // Watchdog limit in sysclk cycles without a tick while a frame is in flight
  localparam int WDOG_LIM = WDOG_MULT * BPS_CNT;
  localparam int WDW      = $clog2(WDOG_LIM + 1);
  localparam int IDXW     = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(DATA_BITS - 1);
  localparam logic [WDW-1:0]  WDOG_MAX  = WDW'(WDOG_LIM);
  localparam logic [WDW-1:0]  WDOG_FIRE = WDW'(WDOG_LIM - 1);

  logic                 sync;
  logic                 fall;
  rx_state_e            state_q;
  logic [IDXW-1:0]      bit_idx_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic [DATA_BITS-1:0] rx_data_q;
  logic [WDW-1:0]       wdog_q;
  logic                 run_q;
  logic                 rx_done_q;
  logic                 frame_err_q;
  logic                 stall_err_q;
  logic                 wdog_hit;
  logic                 abort;

  uart_rx_ctrl_rx_sync_edge u_sync (
    .clk_i   (sysclk),
    .rst_n_i (rst_n),
    .pin_i   (rx_if.rx_pin),
    .sync_o  (sync),
    .fall_o  (fall)
  );

  // A tick on this cycle always beats the watchdog; it fires as the count would reach the limit
  assign wdog_hit = (state_q != ST_IDLE) && !rx_if.clk_bps && (wdog_q >= WDOG_FIRE);
  assign abort    = (state_q != ST_IDLE) && !rx_if.rx_en;

  // Frame sequencer: state, bit index, shift register, watchdog and registered outputs
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      rx_data_q   <= '0;
      wdog_q      <= '0;
      run_q       <= 1'b0;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
      stall_err_q <= 1'b0;
    end else begin
      rx_done_q <= 1'b0;

      if (state_q == ST_IDLE || rx_if.clk_bps) begin
        wdog_q <= '0;
      end else if (wdog_q != WDOG_MAX) begin
        wdog_q <= wdog_q + 1'b1;
      end

      if (abort) begin
        // Disarm mid-frame: drop the frame silently, leave the flags as they were
        state_q <= ST_IDLE;
        run_q   <= 1'b0;
      end else if (wdog_hit) begin
        state_q     <= ST_IDLE;
        run_q       <= 1'b0;
        stall_err_q <= 1'b1;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (fall && rx_if.rx_en) begin
              state_q   <= ST_START;
              run_q     <= 1'b1;
              bit_idx_q <= '0;
            end
          end
          ST_START: begin
            if (rx_if.clk_bps) begin
              if (sync) begin
                // Line back high at mid start bit: glitch, not a frame
                state_q <= ST_IDLE;
                run_q   <= 1'b0;
              end else begin
                state_q <= ST_DATA;
              end
            end
          end
          ST_DATA: begin
            if (rx_if.clk_bps) begin
              shreg_q   <= {sync, shreg_q[DATA_BITS-1:1]};
              bit_idx_q <= bit_idx_q + 1'b1;
              if (bit_idx_q == LAST_IDX) begin
                state_q <= ST_STOP;
              end
            end
          end
          ST_STOP: begin
            if (rx_if.clk_bps) begin
              // Byte is delivered even with a bad stop bit; frame_err tells the consumer
              rx_data_q   <= shreg_q;
              frame_err_q <= ~sync;
              stall_err_q <= 1'b0;
              rx_done_q   <= 1'b1;
              state_q     <= ST_IDLE;
              run_q       <= 1'b0;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            run_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rx_if.count_sig = run_q;
  assign rx_if.busy      = run_q;
  assign rx_if.rx_data   = rx_data_q;
  assign rx_if.rx_done   = rx_done_q;
  assign rx_if.frame_err = frame_err_q;
  assign rx_if.stall_err = stall_err_q;

endmodule
